// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt sequencer.
// Optional nesting support is selected with the INT_SEQ_NESTING_EN macro.
package int_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    CLEAR,
    SETTLE
  } state_t;

  localparam logic [15:0] DEF_VECTOR_BASE  = 16'h0010;
  localparam int          DEF_VECTOR_SHIFT = 2;
  localparam logic        IC_STATUS_ADDR   = 1'b0;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder: index 0 is the highest priority.
// Purely combinational; valid is low when no bit is set.
module int_prio_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer between the interrupt controller and the CPU; owns the controller register port.
// Define INT_SEQ_NESTING_EN to allow priority nesting through the in-service register.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE  = DEF_VECTOR_BASE,
  parameter int          VECTOR_SHIFT = DEF_VECTOR_SHIFT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_rq,
  input  logic [3:0]  int_addr,
  input  logic        cpu_ack,
  input  logic        cpu_reti,
  input  logic        cpu_ce,
  input  logic        cpu_wren,
  input  logic        cpu_ri_addr,
  input  logic [15:0] cpu_data,
  output logic        cpu_irq,
  output logic [15:0] cpu_vector,
  output logic        cpu_wait,
  output logic        ic_ce,
  output logic        ic_wren,
  output logic        ic_ri_addr,
  output logic [15:0] ic_data,
  output logic [15:0] isr
);

  state_t      state, state_d;
  logic [3:0]  addr_q, addr_d;
  logic        irq_d;
  logic [15:0] vector_d;
  logic [15:0] isr_d;
  logic [15:0] isr_reti;
  logic        accept;
  logic [15:0] vector_calc;

  assign vector_calc = VECTOR_BASE + ({12'b0, addr_q} << VECTOR_SHIFT);

`ifdef INT_SEQ_NESTING_EN
  logic [3:0] lvl;
  logic       lvl_vld;

  int_prio_enc u_lvl_enc (
    .vec   (isr),
    .idx   (lvl),
    .valid (lvl_vld)
  );

  assign accept   = !lvl_vld || (addr_q < lvl);
  // With isr empty the mask leaves it empty, so no valid qualifier is needed.
  assign isr_reti = cpu_reti ? (isr & ~(16'h1 << lvl)) : isr;
`else
  assign accept   = (isr == 16'h0);
  assign isr_reti = cpu_reti ? 16'h0 : isr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= 4'd0;
      cpu_irq    <= 1'b0;
      cpu_vector <= 16'h0;
      isr        <= 16'h0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      cpu_irq    <= irq_d;
      cpu_vector <= vector_d;
      isr        <= isr_d;
    end
  end

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    irq_d      = cpu_irq;
    vector_d   = cpu_vector;
    isr_d      = isr_reti;
    ic_ce      = cpu_ce;
    ic_wren    = cpu_wren;
    ic_ri_addr = cpu_ri_addr;
    ic_data    = cpu_data;
    cpu_wait   = 1'b0;

    unique case (state)
      IDLE: begin
        if (int_rq) begin
          addr_d  = int_addr;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          irq_d    = 1'b1;
          vector_d = vector_calc;
          state_d  = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A same-cycle reti has already been folded into isr_reti.
        if (cpu_ack) begin
          isr_d   = isr_reti | (16'h1 << addr_q);
          irq_d   = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ic_ce      = 1'b1;
        ic_wren    = 1'b1;
        ic_ri_addr = IC_STATUS_ADDR;
        ic_data    = ~(16'h1 << addr_q);
        cpu_wait   = cpu_ce;
        state_d    = SETTLE;
      end
      SETTLE: begin
        // Gives the controller a cycle to drop int_rq after the status write.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
